// File: rtl/img_average.sv
// img_average: mean of the dominant channel (avg = sum / num) for each image
// summary coming from the pixel counter stage.
// Summaries are queued in a 2-entry FIFO because the upstream stage never
// stalls. A bit-serial restoring divider produces the quotient and remainder,
// and the result is held on a valid/ready port until it is accepted.
// Optional build macro: IMG_AVERAGE_ROUND_EN adds num/2 to the dividend
// (round-half-up) and runs one more divider step.
module img_average #(
  parameter int IMG_BIT     = 8,
  parameter int TAG_BIT     = 8,
  parameter int TYPE_BIT    = 2,
  parameter int CL_IMG_SIZE = 11,
  parameter int SUM_BIT     = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   img_valid,
  input  logic [TAG_BIT-1:0]     img_tag,
  input  logic [TYPE_BIT-1:0]    img_type,
  input  logic [CL_IMG_SIZE-1:0] img_num,
  input  logic [SUM_BIT-1:0]     img_sum,
  output logic                   avg_valid,
  input  logic                   avg_ready,
  output logic [TAG_BIT-1:0]     avg_tag,
  output logic [TYPE_BIT-1:0]    avg_type,
  output logic [IMG_BIT-1:0]     avg_value,
  output logic [CL_IMG_SIZE-1:0] avg_rem,
  output logic                   avg_err,
  output logic                   err_overflow,
  output logic                   busy
);

`ifdef IMG_AVERAGE_ROUND_EN
  localparam int DW = SUM_BIT + 1;
`else
  localparam int DW = SUM_BIT;
`endif
  localparam int CNT_W = $clog2(DW);
  localparam int EW    = TAG_BIT + TYPE_BIT + CL_IMG_SIZE + SUM_BIT;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;

  // FIFO storage: entry = {tag, type, num, sum}
  logic [EW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    fifo_cnt_q;
  logic          ovf_q;

  logic fifo_empty_s;
  logic fifo_full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  assign fifo_empty_s = (fifo_cnt_q == 2'd0);
  assign fifo_full_s  = (fifo_cnt_q == 2'd2);
  assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_s       = img_valid && (!fifo_full_s || pop_s);
  assign drop_s       = img_valid && fifo_full_s && !pop_s;

  // Head entry unpacked into its fields
  logic [EW-1:0]          head_s;
  logic [TAG_BIT-1:0]     hd_tag_s;
  logic [TYPE_BIT-1:0]    hd_type_s;
  logic [CL_IMG_SIZE-1:0] hd_num_s;
  logic [SUM_BIT-1:0]     hd_sum_s;
  logic [DW-1:0]          dvd_init_s;

  assign head_s    = fifo_q[rd_ptr_q];
  assign hd_tag_s  = head_s[EW-1 -: TAG_BIT];
  assign hd_type_s = head_s[EW-TAG_BIT-1 -: TYPE_BIT];
  assign hd_num_s  = head_s[SUM_BIT +: CL_IMG_SIZE];
  assign hd_sum_s  = head_s[SUM_BIT-1:0];

`ifdef IMG_AVERAGE_ROUND_EN
  assign dvd_init_s = DW'(hd_sum_s) + DW'(hd_num_s >> 1);
`else
  assign dvd_init_s = hd_sum_s;
`endif

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= {img_tag, img_type, img_num, img_sum};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Divider working registers
  logic [DW-1:0]          dvd_q;
  logic [CL_IMG_SIZE-1:0] dvs_q;
  logic [CL_IMG_SIZE-1:0] rem_q;
  logic [DW-2:0]          quo_q;
  logic [CNT_W-1:0]       iter_q;
  logic [TAG_BIT-1:0]     tag_q;
  logic [TYPE_BIT-1:0]    type_q;

  // Registered result port
  logic                   avg_valid_q;
  logic [TAG_BIT-1:0]     avg_tag_q;
  logic [TYPE_BIT-1:0]    avg_type_q;
  logic [IMG_BIT-1:0]     avg_value_q;
  logic [CL_IMG_SIZE-1:0] avg_rem_q;
  logic                   avg_err_q;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  logic [CL_IMG_SIZE:0]   rem_sh_s;
  logic                   ge_s;
  logic [CL_IMG_SIZE-1:0] rem_nx_s;
  logic [DW-1:0]          quo_nx_s;
  logic                   sat_s;

  assign rem_sh_s = {rem_q, dvd_q[DW-1]};
  assign ge_s     = (rem_sh_s >= {1'b0, dvs_q});
  assign rem_nx_s = ge_s ? CL_IMG_SIZE'(rem_sh_s - {1'b0, dvs_q})
                         : rem_sh_s[CL_IMG_SIZE-1:0];
  assign quo_nx_s = {quo_q, ge_s};
  // Divide by zero, or a quotient too wide for the result field.
  assign sat_s    = (dvs_q == {CL_IMG_SIZE{1'b0}}) || (quo_nx_s[DW-1:IMG_BIT] != '0);

  // Control FSM: pop, iterate the divider, hold the result until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      iter_q      <= '0;
      tag_q       <= '0;
      type_q      <= '0;
      avg_valid_q <= 1'b0;
      avg_tag_q   <= '0;
      avg_type_q  <= '0;
      avg_value_q <= '0;
      avg_rem_q   <= '0;
      avg_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            dvd_q   <= dvd_init_s;
            dvs_q   <= hd_num_s;
            rem_q   <= '0;
            quo_q   <= '0;
            iter_q  <= CNT_W'(DW - 1);
            tag_q   <= hd_tag_s;
            type_q  <= hd_type_s;
            state_q <= S_DIV;
          end
        end
        S_DIV: begin
          dvd_q  <= {dvd_q[DW-2:0], 1'b0};
          rem_q  <= rem_nx_s;
          quo_q  <= quo_nx_s[DW-2:0];
          iter_q <= iter_q - CNT_W'(1);
          if (iter_q == '0) begin
            avg_valid_q <= 1'b1;
            avg_tag_q   <= tag_q;
            avg_type_q  <= type_q;
            avg_value_q <= sat_s ? {IMG_BIT{1'b1}} : quo_nx_s[IMG_BIT-1:0];
            avg_rem_q   <= sat_s ? {CL_IMG_SIZE{1'b0}} : rem_nx_s;
            avg_err_q   <= sat_s;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (avg_ready) begin
            avg_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign avg_valid    = avg_valid_q;
  assign avg_tag      = avg_tag_q;
  assign avg_type     = avg_type_q;
  assign avg_value    = avg_value_q;
  assign avg_rem      = avg_rem_q;
  assign avg_err      = avg_err_q;
  assign err_overflow = ovf_q;
  assign busy         = !fifo_empty_s || (state_q != S_IDLE);

endmodule
